// File: rtl/dsp_p_serializer.sv
// Serializes WIDTH-bit DSP P words into N = WIDTH/SLICE beats through a 2-entry word FIFO.
// Define DSP_SER_MSB_FIRST_EN to send the most-significant slice first; the default is LSB first.
module dsp_p_serializer #(
  parameter int WIDTH = 48,
  parameter int SLICE = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CEN,
  input  logic [WIDTH-1:0] P_IN,
  input  logic             P_VLD,
  output logic             P_RDY,
  output logic [SLICE-1:0] DOUT,
  output logic             DOUT_VLD,
  input  logic             DOUT_RDY,
  output logic             DOUT_LAST,
  output logic             BUSY
);

  localparam int N  = WIDTH / SLICE;
  localparam int BW = $clog2(N);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [BW-1:0]    beat_q, beat_d;

  logic             empty, full;
  logic             push, beat_xfer, pop, at_last;
  logic [WIDTH-1:0] head;
  logic [BW-1:0]    slice_idx;

  // State register and FIFO bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
    end
  end

  // NOTE: word storage is not reset; DOUT is forced to 0 whenever the FIFO is empty instead.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= P_IN;
  end

  // Handshake decode and counter updates. A full FIFO never takes a push, even while popping,
  // which keeps P_RDY free of any path from DOUT_RDY.
  always_comb begin
    empty     = (state_q == IDLE);
    full      = (count_q == 2'd2);
    push      = P_VLD && P_RDY;
    beat_xfer = DOUT_VLD && DOUT_RDY;
    at_last   = (beat_q == BW'(N - 1));
    pop       = beat_xfer && at_last;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    beat_d    = beat_q;
    if (beat_xfer) beat_d = at_last ? '0 : beat_q + BW'(1);
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = SHIFT;
      SHIFT:   if (count_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
`ifdef DSP_SER_MSB_FIRST_EN
    slice_idx = BW'(N - 1) - beat_q;
`else
    slice_idx = beat_q;
`endif
    P_RDY     = CEN && !full && RST_N;
    DOUT_VLD  = CEN && !empty;
    DOUT_LAST = DOUT_VLD && at_last;
    BUSY      = !empty;
    DOUT      = empty ? '0 : head[SLICE*int'(slice_idx) +: SLICE];
  end

endmodule

// File: tb/tb_dsp_p_serializer.sv
// Scoreboard bench for dsp_p_serializer: a word-level model predicts beats and handshakes,
// a negedge monitor compares every presented beat and the ready/valid/busy flags.
module tb_dsp_p_serializer;

  localparam int WIDTH = 48;
  localparam int SLICE = 16;
  localparam int N     = WIDTH / SLICE;

  logic             CLK = 1'b0;
  logic             RST_N, CEN, P_VLD, DOUT_RDY;
  logic [WIDTH-1:0] P_IN;
  logic             P_RDY, DOUT_VLD, DOUT_LAST, BUSY;
  logic [SLICE-1:0] DOUT;

  typedef struct {
    logic [SLICE-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  dsp_p_serializer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .CLK(CLK), .RST_N(RST_N), .CEN(CEN), .P_IN(P_IN), .P_VLD(P_VLD), .P_RDY(P_RDY),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_RDY(DOUT_RDY), .DOUT_LAST(DOUT_LAST), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word becomes N slices in transmission order; only the final one is marked last.
  task automatic model_push(input logic [WIDTH-1:0] w);
    beat_t b;
    for (int i = 0; i < N; i++) begin
`ifdef DSP_SER_MSB_FIRST_EN
      b.data = w[(N-1-i)*SLICE +: SLICE];
`else
      b.data = w[i*SLICE +: SLICE];
`endif
      b.last = (i == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: the negedge view of the handshakes is what the next rising edge will act on.
  always @(negedge CLK) begin
    int occ;
    if (!RST_N) begin
      exp_q.delete();
      check("reset_outputs", {P_RDY, DOUT_VLD, DOUT_LAST, BUSY, DOUT}, '0);
    end else begin
      occ = (exp_q.size() + N - 1) / N;
      check("p_rdy", P_RDY, CEN && occ < 2);
      check("dout_vld", DOUT_VLD, CEN && occ > 0);
      check("busy", BUSY, occ > 0);
      if (!DOUT_VLD) check("dout_last_idle", DOUT_LAST, 0);
      if (DOUT_VLD && exp_q.size() == 0) check("dout_spurious", DOUT_VLD, 0);
      if (DOUT_VLD && exp_q.size() > 0) begin
        check("dout", DOUT, exp_q[0].data);
        check("dout_last", DOUT_LAST, exp_q[0].last);
        if (DOUT_RDY) void'(exp_q.pop_front());
      end
      if (P_VLD && CEN && occ < 2) model_push(P_IN);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] w);
    P_IN  = w;
    P_VLD = 1'b1;
    tick();
    P_VLD = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    P_VLD    = 1'b0;
    DOUT_RDY = 1'b1;
    CEN      = 1'b1;
    while (exp_q.size() != 0 && k < max_cycles) begin
      tick();
      k++;
    end
    tick();
    check("drained_beats_left", exp_q.size(), 0);
    check("busy_after_drain", BUSY, 0);
  endtask

  initial begin
    int  k;
    logic accepted;
    RST_N = 1'b0; CEN = 1'b1; P_VLD = 1'b0; DOUT_RDY = 1'b0; P_IN = '0;
    #2;
    check("reset_before_clock", {P_RDY, DOUT_VLD, DOUT_LAST, BUSY, DOUT}, '0);
    repeat (3) tick();
    RST_N = 1'b1;
    tick();

    // Single word, LSB slice first.
    DOUT_RDY = 1'b1;
    push_one(48'h1111_2222_3333);
    drain(20);

    // Back-to-back words, then a third push that must stall while the FIFO is full.
    P_IN = 48'hAAAA_BBBB_CCCC; P_VLD = 1'b1; tick();
    P_IN = 48'h4444_5555_6666; tick();
    P_IN = 48'h7777_8888_9999;
    k = 0;
    do begin
      accepted = P_RDY;
      tick();
      k++;
    end while (!accepted && k < 20);
    P_VLD = 1'b0;
    check("third_push_stall_cycles", k, 3);
    drain(30);

    // Backpressure on the middle beat for 5 cycles.
    push_one(48'h1111_2222_3333);
    tick();
    DOUT_RDY = 1'b0;
    repeat (5) tick();
    check("held_beat", DOUT, 16'h2222);
    DOUT_RDY = 1'b1;
    drain(20);

    // Reset in mid-word after the first beat transfers.
    push_one(48'h1111_2222_3333);
    tick();
    #2 RST_N = 1'b0;
    #1 check("async_reset_outputs", {P_RDY, DOUT_VLD, DOUT_LAST, BUSY, DOUT}, '0);
    tick();
    RST_N = 1'b1;
    tick();
    check("p_rdy_after_reset", P_RDY, 1);
    push_one(48'h0000_0000_0007);
    drain(20);

    // Clock enable dropped for 3 cycles while both sides are willing.
    P_VLD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      P_IN = {16'(i), 16'hC0DE, 16'(i + 100)};
      CEN  = !(i >= 3 && i < 6);
      tick();
    end
    CEN = 1'b1;
    drain(40);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      P_IN     = {$urandom, $urandom};
      P_VLD    = ($urandom_range(0, 2) != 0);
      DOUT_RDY = ($urandom_range(0, 3) != 0);
      CEN      = ($urandom_range(0, 9) != 0);
      tick();
    end
    drain(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dsp_p_serializer.md
DSP_P_SERIALIZER -- requirements
Module: dsp_p_serializer

Interface
REQ-001 Parameter WIDTH, default 48, width of the P result word accepted from the DSP pipeline.
REQ-002 Parameter SLICE, default 16, width of one output beat; WIDTH SHALL be an integer multiple of SLICE, with N = WIDTH/SLICE >= 2.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 CEN  input  1  clock enable; when low, all state is frozen.
REQ-006 P_IN  input  WIDTH  result word from the pipeline.
REQ-007 P_VLD  input  1  P_IN valid.
REQ-008 P_RDY  output  1  block can accept a word.
REQ-009 DOUT  output  SLICE  current output beat.
REQ-010 DOUT_VLD  output  1  DOUT valid.
REQ-011 DOUT_RDY  input  1  downstream accepts the beat.
REQ-012 DOUT_LAST  output  1  the current beat is beat N-1 of its word.
REQ-013 BUSY  output  1  at least one word is held.

Function
REQ-014 The block SHALL contain a 2-entry word FIFO and a beat counter BEAT, with range 0..N-1, for the head word.
REQ-015 A push SHALL occur on a rising edge with P_VLD && P_RDY && CEN.
REQ-016 A beat transfer SHALL occur on a rising edge with DOUT_VLD && DOUT_RDY && CEN.
REQ-017 P_RDY SHALL be CEN && !full && RST_N, with no combinational path from DOUT_RDY; a full FIFO SHALL NOT accept a push in the same cycle it pops.
REQ-018 DOUT_VLD SHALL be CEN && !empty.
REQ-019 DOUT SHALL be head[SLICE*BEAT +: SLICE], so the least-significant slice is sent first.
REQ-020 DOUT_LAST SHALL be DOUT_VLD && (BEAT == N-1).
REQ-021 States: IDLE (empty) and SHIFT (non-empty).
REQ-022 IDLE to SHIFT on a push.
REQ-023 On a beat transfer with BEAT < N-1, BEAT SHALL increment.
REQ-024 On a beat transfer with BEAT == N-1:
- the head SHALL be popped;
- BEAT SHALL wrap to 0;
- the block SHALL stay in SHIFT if the other entry is valid, or the entry pushed in that same cycle, with no bubble cycle;
- otherwise it SHALL return to IDLE.
REQ-025 Latency: a word pushed into an empty block at edge k SHALL present beat 0 on DOUT in the cycle after edge k.
REQ-026 While DOUT_VLD && !DOUT_RDY, DOUT, DOUT_LAST and BEAT SHALL hold stable.
REQ-027 A simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1.
REQ-028 With CEN low, no push, pop or BEAT change SHALL occur, and P_RDY and DOUT_VLD SHALL read 0.
REQ-029 BUSY SHALL be !empty, independent of CEN.

Reset
REQ-030 While RST_N is low, irrespective of CLK:
- the FIFO SHALL be empty;
- BEAT SHALL be 0;
- state SHALL be IDLE;
- P_RDY, DOUT_VLD, DOUT_LAST and BUSY SHALL be 0;
- DOUT SHALL be 0.
REQ-031 A reset in mid-word SHALL discard all held words and partial beats; the first beat after release SHALL be beat 0 of a newly pushed word.
REQ-032 P_RDY SHALL return to 1 in the first cycle after RST_N deasserts while CEN is high.

Configuration
REQ-033 Macro DSP_SER_MSB_FIRST_EN.
- Defined: DOUT SHALL be head[SLICE*(N-1-BEAT) +: SLICE], most-significant slice first.
- Undefined: order per REQ-019.
- In both cases DOUT_LAST SHALL mark beat N-1 and all handshake timing SHALL be identical.

Verification
REQ-034 Single word: after reset, push P_IN=0x111122223333 with DOUT_RDY=1.
- Required: DOUT = 0x3333, 0x2222, 0x1111 on three consecutive cycles starting one cycle after the push.
- Required: DOUT_LAST high only on the 0x1111 beat; BUSY low afterwards.
REQ-035 Back-to-back: push 0xAAAABBBBCCCC then 0x444455556666 on consecutive cycles, DOUT_RDY=1.
- Required: six contiguous beats CCCC, BBBB, AAAA, 6666, 5555, 4444.
- Required: a third push is stalled (P_RDY=0) until the AAAA beat transfers.
REQ-036 Backpressure: hold DOUT_RDY=0 for 5 cycles on beat 0x2222.
- Required: DOUT stays 0x2222 with DOUT_VLD=1.
- Required: the sequence resumes with 0x1111 after DOUT_RDY rises.
REQ-037 Reset mid-word: assert RST_N=0 after the 0x3333 beat transfers.
- Required: outputs drop to 0 asynchronously.
- Required: after release, a push of 0x000000000007 yields DOUT 0x0007, 0x0000, 0x0000.
REQ-038 CEN: drop CEN for 3 cycles while P_VLD=1 and DOUT_RDY=1.
- Required: P_RDY and DOUT_VLD read 0, and no beat or word is lost or duplicated.
REQ-039 With DSP_SER_MSB_FIRST_EN defined, the scenario of REQ-034 SHALL yield 0x1111, 0x2222, 0x3333 with DOUT_LAST on 0x3333.
